// File: rtl/adder_top_if.sv
// Operand/result bundle for the 8-bit registered lookahead adder.
// The master drives operands; the slave returns the registered sum.
interface adder_top_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;

    modport master (
        output a,
        output b,
        output cin,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output s,
        output cout
    );
endinterface

// File: rtl/adder_top.sv
// 8-bit two-level carry-lookahead adder with a single output register.
// Two 4-bit lookahead groups joined by a second-level group lookahead.
module adder_top (
    input  logic       clk,
    input  logic       rst,
    adder_top_if.slave bus
);
    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] c;
    logic [4:0] grp0;
    logic [4:0] grp1;
    logic       c4;
    logic       c8;
    logic [7:0] s_next;

    // Returns {GG, PG, c3, c2, c1} for one 4-bit group.
    function automatic logic [4:0] cla4(
        input logic [3:0] pp,
        input logic [3:0] gg,
        input logic       ci
    );
        logic [4:0] r;
        r[0] = gg[0]
             | (pp[0] & ci);
        r[1] = gg[1]
             | (pp[1] & gg[0])
             | (pp[1] & pp[0] & ci);
        r[2] = gg[2]
             | (pp[2] & gg[1])
             | (pp[2] & pp[1] & gg[0])
             | (pp[2] & pp[1] & pp[0] & ci);
        r[3] = &pp;
        r[4] = gg[3]
             | (pp[3] & gg[2])
             | (pp[3] & pp[2] & gg[1])
             | (pp[3] & pp[2] & pp[1] & gg[0]);
        return r;
    endfunction

    always_comb begin
        p    = bus.a ^ bus.b;
        g    = bus.a & bus.b;
        grp0 = cla4(p[3:0], g[3:0], bus.cin);
        c4   = grp0[4] | (grp0[3] & bus.cin);
        c8   = grp1[4]
             | (grp1[3] & grp0[4])
             | (grp1[3] & grp0[3] & bus.cin);
        c    = {grp1[2:0], c4, grp0[2:0], bus.cin};
        s_next = p ^ c;
    end

    // Group 1 is fed from the second-level c4, never from group 0 sums.
    assign grp1 = cla4(p[7:4], g[7:4], c4);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s    <= 8'h00;
            bus.cout <= 1'b0;
        end else begin
            bus.s    <= s_next;
            bus.cout <= c8;
        end
    end
endmodule

// File: tb/tb_adder_top.sv
// Directed and random checks for the registered 8-bit lookahead adder.
// Results are compared one edge after the inputs are applied.
module tb_adder_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    adder_top_if bus ();

    adder_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.cout, bus.s};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] ref_sum;

        rst = 1'b1;
        apply(8'hFF, 8'hFF, 1'b1);
        step();
        check("reset_edge1", 9'h000);
        step();
        check("reset_edge2", 9'h000);

        rst = 1'b0;
        step();
        check("release_ff_ff_1", 9'h1FF);

        apply(8'd10, 8'd20, 1'b0);
        step();
        check("10+20+0", 9'd30);

        apply(8'd100, 8'd100, 1'b1);
        step();
        check("100+100+1", 9'd201);

        apply(8'd255, 8'd1, 1'b0);
        step();
        check("255+1+0", 9'h100);

        apply(8'd255, 8'd0, 1'b1);
        step();
        check("255+0+1", 9'h100);

        apply(8'b10101010, 8'b01010101, 1'b0);
        step();
        check("alt_cin0", 9'h0FF);

        apply(8'b10101010, 8'b01010101, 1'b1);
        step();
        check("alt_cin1_propagate", 9'h100);

        apply(8'h0F, 8'h01, 1'b0);
        step();
        check("group_c4_gen", 9'h010);

        apply(8'h80, 8'h80, 1'b0);
        step();
        check("msb_gen", 9'h100);

        // Back-to-back stream with a reset in the middle cycle.
        apply(8'd1, 8'd2, 1'b0);
        step();
        check("b2b_1", 9'd3);
        apply(8'd50, 8'd60, 1'b1);
        step();
        check("b2b_2", 9'd111);
        apply(8'd200, 8'd100, 1'b0);
        @(negedge clk);
        check("b2b_hold", 9'd111);
        step();
        check("b2b_3", 9'd300);

        apply(8'd7, 8'd9, 1'b1);
        rst = 1'b1;
        step();
        check("mid_reset", 9'h000);
        rst = 1'b0;
        apply(8'd33, 8'd44, 1'b0);
        step();
        check("after_reset_1", 9'd77);
        apply(8'd240, 8'd15, 1'b1);
        step();
        check("after_reset_2", 9'h100);

        for (int i = 0; i < 12000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            apply(ra, rb, rc);
            step();
            check("random", ref_sum);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
